// File: rtl/store_buffer_if.sv
// Shared payload type and the LSU/commit/memory-side bundle of the store buffer.
//   store_buffer_pkg : field widths and the packed per-entry payload
//   store_buffer_if  : store push, commit, flush, alias check and memory drain signals
//     modport slave  : the store buffer itself
//     modport master : the surrounding pipeline / memory model
package store_buffer_pkg;
    localparam int unsigned ADDR_W = 64;
    localparam int unsigned DATA_W = 64;
    localparam int unsigned BE_W   = 8;
    localparam int unsigned SIZE_W = 2;
    localparam int unsigned OFFS_W = 12;

    typedef struct packed {
        logic [ADDR_W-1:0] paddr;
        logic [DATA_W-1:0] data;
        logic [BE_W-1:0]   be;
        logic [SIZE_W-1:0] size;
    } sb_entry_t;
endpackage

interface store_buffer_if;
    import store_buffer_pkg::*;

    logic              flush_i;
    logic              valid_i;
    logic [ADDR_W-1:0] paddr_i;
    logic [DATA_W-1:0] data_i;
    logic [BE_W-1:0]   be_i;
    logic [SIZE_W-1:0] data_size_i;
    logic              ready_o;
    logic              commit_i;
    logic              commit_ready_o;
    logic [OFFS_W-1:0] page_offset_i;
    logic              page_offset_matches_o;
    logic              store_buffer_empty_o;
    logic              no_st_pending_o;
    logic              mem_req_o;
    logic              mem_gnt_i;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_data_o;
    logic [BE_W-1:0]   mem_be_o;
    logic [SIZE_W-1:0] mem_size_o;

    modport slave (
        input  flush_i, valid_i, paddr_i, data_i, be_i, data_size_i,
        input  commit_i, page_offset_i, mem_gnt_i,
        output ready_o, commit_ready_o, page_offset_matches_o,
        output store_buffer_empty_o, no_st_pending_o,
        output mem_req_o, mem_addr_o, mem_data_o, mem_be_o, mem_size_o
    );

    modport master (
        output flush_i, valid_i, paddr_i, data_i, be_i, data_size_i,
        output commit_i, page_offset_i, mem_gnt_i,
        input  ready_o, commit_ready_o, page_offset_matches_o,
        input  store_buffer_empty_o, no_st_pending_o,
        input  mem_req_o, mem_addr_o, mem_data_o, mem_be_o, mem_size_o
    );
endinterface

// File: rtl/store_buffer.sv
// Physical-address store buffer: holds stores speculatively until committed,
// then drains them in program order to the data cache via req/gnt.
//   clk_i  : clock, rising edge
//   rst_ni : synchronous active-low reset
//   sb     : store_buffer_if.slave (push/commit/flush, alias check, memory drain)
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    store_buffer_if.slave sb
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned TOT_W = CNT_W + 1;

    sb_entry_t        mem_q [DEPTH];
    logic [PTR_W-1:0] head_q, commit_q, tail_q;
    logic [PTR_W-1:0] head_d, commit_d, tail_d;
    logic [CNT_W-1:0] commit_cnt_q, spec_cnt_q;
    logic [CNT_W-1:0] commit_cnt_d, spec_cnt_d;

    logic             push, commit, gnt;
    logic             ready, commit_ready, mem_req;
    logic [TOT_W-1:0] total;
    logic [DEPTH-1:0] occupied;
    logic [PTR_W-1:0] rel [DEPTH];
    logic             match;
    sb_entry_t        in_entry;
    sb_entry_t        head_entry;

    // Status derived from registered counts only
    assign total        = TOT_W'(commit_cnt_q) + TOT_W'(spec_cnt_q);
    assign ready        = total < TOT_W'(DEPTH);
    assign commit_ready = spec_cnt_q != '0;
    assign mem_req      = commit_cnt_q != '0;

    assign in_entry   = '{paddr: sb.paddr_i, data: sb.data_i, be: sb.be_i, size: sb.data_size_i};
    assign head_entry = mem_q[head_q];

    // Next-state for pointers and counters; flush rewinds tail after the commit
    always_comb begin
        push         = sb.valid_i & ready & ~sb.flush_i;
        commit       = sb.commit_i & commit_ready;
        gnt          = mem_req & sb.mem_gnt_i;
        head_d       = head_q;
        commit_d     = commit_q;
        tail_d       = tail_q;
        commit_cnt_d = commit_cnt_q + CNT_W'(commit) - CNT_W'(gnt);
        spec_cnt_d   = spec_cnt_q + CNT_W'(push) - CNT_W'(commit);
        if (gnt) begin
            head_d = head_q + PTR_W'(1);
        end
        if (commit) begin
            commit_d = commit_q + PTR_W'(1);
        end
        if (push) begin
            tail_d = tail_q + PTR_W'(1);
        end
        if (sb.flush_i) begin
            tail_d     = commit_d;
            spec_cnt_d = '0;
        end
    end

    // State register and entry storage
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            head_q       <= '0;
            commit_q     <= '0;
            tail_q       <= '0;
            commit_cnt_q <= '0;
            spec_cnt_q   <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            head_q       <= head_d;
            commit_q     <= commit_d;
            tail_q       <= tail_d;
            commit_cnt_q <= commit_cnt_d;
            spec_cnt_q   <= spec_cnt_d;
            if (push) begin
                mem_q[tail_q] <= in_entry;
            end
        end
    end

    // Alias check: an entry is live when its distance from head is below the total count
    always_comb begin
        occupied = '0;
        match    = sb.valid_i && (sb.paddr_i[11:3] == sb.page_offset_i[11:3]);
        for (int unsigned i = 0; i < DEPTH; i++) begin
            rel[i]      = PTR_W'(i) - head_q;
            occupied[i] = TOT_W'(rel[i]) < total;
            match       = match | (occupied[i] && (mem_q[i].paddr[11:3] == sb.page_offset_i[11:3]));
        end
    end

    assign sb.ready_o               = ready;
    assign sb.commit_ready_o        = commit_ready;
    assign sb.page_offset_matches_o = match;
    assign sb.store_buffer_empty_o  = total == '0;
    assign sb.no_st_pending_o       = commit_cnt_q == '0;
    assign sb.mem_req_o             = mem_req;
    assign sb.mem_addr_o            = head_entry.paddr;
    assign sb.mem_data_o            = head_entry.data;
    assign sb.mem_be_o              = head_entry.be;
    assign sb.mem_size_o            = head_entry.size;
endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed stimulus, expected drains queued
// at commit time and checked by an independent memory-side monitor.
module tb_store_buffer;
    import store_buffer_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_err = 0;
    int   n_gnt = 0;
    sb_entry_t exp_q[$];
    sb_entry_t cur;

    always #5 clk = ~clk;

    store_buffer_if sb ();

    store_buffer #(.DEPTH(8)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .sb     (sb)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        sb.flush_i       = 1'b0;
        sb.valid_i       = 1'b0;
        sb.paddr_i       = '0;
        sb.data_i        = '0;
        sb.be_i          = '0;
        sb.data_size_i   = '0;
        sb.commit_i      = 1'b0;
        sb.mem_gnt_i     = 1'b0;
        sb.page_offset_i = 12'hFFF;
    endtask

    task automatic drive_store(input logic [63:0] a, input logic [63:0] d,
                               input logic [7:0] be, input logic [1:0] sz);
        sb.valid_i     = 1'b1;
        sb.paddr_i     = a;
        sb.data_i      = d;
        sb.be_i        = be;
        sb.data_size_i = sz;
    endtask

    // Memory-side monitor: every presented request must match the oldest committed store
    always @(negedge clk) begin
        if (rst_n === 1'b1 && sb.mem_req_o === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_req: got addr 0x%0h expected no request", sb.mem_addr_o);
            end else begin
                cur = exp_q[0];
                check("mem_addr", sb.mem_addr_o, cur.paddr);
                check("mem_data", sb.mem_data_o, cur.data);
                check("mem_be",   64'(sb.mem_be_o), 64'(cur.be));
                check("mem_size", 64'(sb.mem_size_o), 64'(cur.size));
                if (sb.mem_gnt_i === 1'b1) begin
                    void'(exp_q.pop_front());
                    n_gnt++;
                end
            end
        end
    end

    initial begin
        int gnt_base;
        idle();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;

        // Reset state
        check("rst_ready", 64'(sb.ready_o), 64'd1);
        check("rst_commit_ready", 64'(sb.commit_ready_o), 64'd0);
        check("rst_empty", 64'(sb.store_buffer_empty_o), 64'd1);
        check("rst_no_pending", 64'(sb.no_st_pending_o), 64'd1);
        check("rst_req", 64'(sb.mem_req_o), 64'd0);
        check("rst_addr", sb.mem_addr_o, 64'd0);
        check("rst_match", 64'(sb.page_offset_matches_o), 64'd0);

        // Single store, stalled grant for 3 cycles
        drive_store(64'h8000_0010, 64'hDEAD_BEEF, 8'h0F, 2'b10);
        step();
        idle();
        check("t1_commit_ready", 64'(sb.commit_ready_o), 64'd1);
        check("t1_req_before_commit", 64'(sb.mem_req_o), 64'd0);
        sb.commit_i = 1'b1;
        exp_q.push_back('{paddr: 64'h8000_0010, data: 64'hDEAD_BEEF, be: 8'h0F, size: 2'b10});
        step();
        idle();
        for (int i = 0; i < 3; i++) begin
            check("t1_req_stall", 64'(sb.mem_req_o), 64'd1);
            step();
        end
        sb.mem_gnt_i = 1'b1;
        step();
        idle();
        check("t1_req_after_gnt", 64'(sb.mem_req_o), 64'd0);
        check("t1_no_pending", 64'(sb.no_st_pending_o), 64'd1);
        check("t1_empty", 64'(sb.store_buffer_empty_o), 64'd1);

        // Fill all 8 entries, 9th push ignored, then commit and drain in order
        for (int i = 0; i < 8; i++) begin
            check("t2_ready_fill", 64'(sb.ready_o), 64'd1);
            drive_store(64'h1000 + 64'(i * 8), 64'h1111_0000 + 64'(i), 8'hFF, 2'b11);
            step();
        end
        idle();
        check("t2_ready_full", 64'(sb.ready_o), 64'd0);
        drive_store(64'h9999_0000, 64'hBAD, 8'hFF, 2'b11);
        step();
        idle();
        check("t2_ready_9th", 64'(sb.ready_o), 64'd0);
        check("t2_empty_9th", 64'(sb.store_buffer_empty_o), 64'd0);
        for (int i = 0; i < 8; i++) begin
            check("t2_commit_ready", 64'(sb.commit_ready_o), 64'd1);
            sb.commit_i = 1'b1;
            exp_q.push_back('{paddr: 64'h1000 + 64'(i * 8), data: 64'h1111_0000 + 64'(i),
                              be: 8'hFF, size: 2'b11});
            step();
        end
        idle();
        check("t2_spec_exhausted", 64'(sb.commit_ready_o), 64'd0);
        check("t2_ready_still_full", 64'(sb.ready_o), 64'd0);
        sb.mem_gnt_i = 1'b1;
        for (int i = 0; i < 8; i++) step();
        idle();
        check("t2_req_done", 64'(sb.mem_req_o), 64'd0);
        check("t2_ready_after", 64'(sb.ready_o), 64'd1);
        check("t2_empty_after", 64'(sb.store_buffer_empty_o), 64'd1);

        // Flush with a committed entry and a same-cycle push
        drive_store(64'hA0, 64'hAAAA, 8'h01, 2'b00);
        step();
        drive_store(64'hB0, 64'hBBBB, 8'h03, 2'b01);
        step();
        drive_store(64'hC0, 64'hCCCC, 8'h0F, 2'b10);
        step();
        idle();
        sb.commit_i = 1'b1;
        exp_q.push_back('{paddr: 64'hA0, data: 64'hAAAA, be: 8'h01, size: 2'b00});
        step();
        idle();
        sb.flush_i = 1'b1;
        drive_store(64'hD0, 64'hDDDD, 8'hFF, 2'b11);
        step();
        idle();
        check("t3_commit_ready", 64'(sb.commit_ready_o), 64'd0);
        check("t3_empty_pre", 64'(sb.store_buffer_empty_o), 64'd0);
        check("t3_req", 64'(sb.mem_req_o), 64'd1);
        sb.mem_gnt_i = 1'b1;
        step();
        idle();
        check("t3_req_after", 64'(sb.mem_req_o), 64'd0);
        check("t3_empty_after", 64'(sb.store_buffer_empty_o), 64'd1);
        check("t3_commit_ready_after", 64'(sb.commit_ready_o), 64'd0);
        step();
        step();

        // Simultaneous push, commit and grant with one committed and one speculative entry
        drive_store(64'h300, 64'h3333, 8'hF0, 2'b10);
        step();
        drive_store(64'h308, 64'h3434, 8'h0F, 2'b10);
        sb.commit_i = 1'b1;
        exp_q.push_back('{paddr: 64'h300, data: 64'h3333, be: 8'hF0, size: 2'b10});
        step();
        drive_store(64'h310, 64'h3535, 8'hFF, 2'b11);
        sb.commit_i  = 1'b1;
        sb.mem_gnt_i = 1'b1;
        exp_q.push_back('{paddr: 64'h308, data: 64'h3434, be: 8'h0F, size: 2'b10});
        step();
        idle();
        check("t4_commit_ready", 64'(sb.commit_ready_o), 64'd1);
        check("t4_no_pending", 64'(sb.no_st_pending_o), 64'd0);
        check("t4_req", 64'(sb.mem_req_o), 64'd1);
        sb.commit_i  = 1'b1;
        sb.mem_gnt_i = 1'b1;
        exp_q.push_back('{paddr: 64'h310, data: 64'h3535, be: 8'hFF, size: 2'b11});
        step();
        idle();
        check("t4_spec_was_one", 64'(sb.commit_ready_o), 64'd0);
        sb.mem_gnt_i = 1'b1;
        step();
        idle();
        check("t4_empty", 64'(sb.store_buffer_empty_o), 64'd1);

        // Alias check against a buffered store and the incoming store
        drive_store(64'h1238, 64'h77, 8'hFF, 2'b11);
        step();
        idle();
        sb.page_offset_i = 12'h23C;
        #1;
        check("t5_match_buffered", 64'(sb.page_offset_matches_o), 64'd1);
        sb.page_offset_i = 12'h240;
        #1;
        check("t5_nomatch", 64'(sb.page_offset_matches_o), 64'd0);
        drive_store(64'h5240, 64'h88, 8'hFF, 2'b11);
        #1;
        check("t5_match_incoming", 64'(sb.page_offset_matches_o), 64'd1);
        sb.valid_i = 1'b0;
        sb.flush_i = 1'b1;
        step();
        idle();
        sb.page_offset_i = 12'h23C;
        #1;
        check("t5_flushed_nomatch", 64'(sb.page_offset_matches_o), 64'd0);
        check("t5_empty", 64'(sb.store_buffer_empty_o), 64'd1);

        // Wrap: 20 rounds with grant delays 0..3
        gnt_base = n_gnt;
        for (int r = 0; r < 20; r++) begin
            drive_store(64'h2000 + 64'(r * 8), 64'hC0DE_0000 + 64'(r), 8'(r + 1), 2'(r));
            step();
            idle();
            sb.commit_i = 1'b1;
            exp_q.push_back('{paddr: 64'h2000 + 64'(r * 8), data: 64'hC0DE_0000 + 64'(r),
                              be: 8'(r + 1), size: 2'(r)});
            step();
            idle();
            for (int d = 0; d < (r % 4); d++) step();
            sb.mem_gnt_i = 1'b1;
            step();
            idle();
        end
        check("t6_grant_count", 64'(n_gnt - gnt_base), 64'd20);
        check("t6_queue_drained", 64'(exp_q.size()), 64'd0);
        check("t6_empty", 64'(sb.store_buffer_empty_o), 64'd1);

        // Reset in the middle of a pending drain drops the committed entry
        drive_store(64'h4000, 64'h4444, 8'hFF, 2'b11);
        step();
        idle();
        sb.commit_i = 1'b1;
        exp_q.push_back('{paddr: 64'h4000, data: 64'h4444, be: 8'hFF, size: 2'b11});
        step();
        idle();
        check("t7_req_pre", 64'(sb.mem_req_o), 64'd1);
        rst_n = 1'b0;
        step();
        exp_q.delete();
        check("t7_req_reset", 64'(sb.mem_req_o), 64'd0);
        check("t7_empty_reset", 64'(sb.store_buffer_empty_o), 64'd1);
        check("t7_addr_reset", sb.mem_addr_o, 64'd0);
        rst_n = 1'b1;
        step();
        check("t7_req_after", 64'(sb.mem_req_o), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
